// File: rtl/zeroriscy_perf_counters_pkg.sv
// Shared CSR encodings, addresses and the event-select field layout for the perf counters.
package zeroriscy_perf_counters_pkg;

  // CSR operation encodings shared with the core CSR file
  localparam logic [1:0] CSR_OP_NONE  = 2'b00;
  localparam logic [1:0] CSR_OP_WRITE = 2'b01;
  localparam logic [1:0] CSR_OP_SET   = 2'b10;
  localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

  localparam logic [11:0] CSR_PERF_CNT_LO_BASE = 12'hB03;
  localparam logic [11:0] CSR_PERF_CNT_HI_BASE = 12'hB83;
  localparam logic [11:0] CSR_PERF_EVSEL_BASE  = 12'h323;
  localparam logic [11:0] CSR_PERF_INHIBIT     = 12'h320;
  localparam logic [11:0] CSR_PERF_OVF         = 12'h7C0;

  typedef struct packed {
    logic       ovf_en;
    logic       sat;
    logic [4:0] idx;
  } EvSel_t;

  // EVSEL register layout: [31] ovf_en, [30] sat, [4:0] idx, everything else reads 0
  function automatic EvSel_t evsel_from_word(logic [31:0] w);
    EvSel_t e;
    e.ovf_en = w[31];
    e.sat    = w[30];
    e.idx    = w[4:0];
    return e;
  endfunction

  function automatic logic [31:0] evsel_to_word(EvSel_t e);
    return {e.ovf_en, e.sat, 25'b0, e.idx};
  endfunction

endpackage

// File: rtl/zeroriscy_perf_counters_if.sv
// SRAM-like CSR bus between the CSR file (master) and the perf-counter unit (slave).
interface zeroriscy_perf_counters_if;
  logic        csr_access_i;
  logic [11:0] csr_addr_i;
  logic [31:0] csr_wdata_i;
  logic [1:0]  csr_op_i;
  logic [31:0] csr_rdata_o;
  logic        csr_hit_o;

  modport master (
    output csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
    input  csr_rdata_o, csr_hit_o
  );

  modport slave (
    input  csr_access_i, csr_addr_i, csr_wdata_i, csr_op_i,
    output csr_rdata_o, csr_hit_o
  );
endinterface

// File: rtl/zeroriscy_perf_counter.sv
// One performance counter: increment with wrap or saturate, plus half-word software writes.
module zeroriscy_perf_counter #(
  parameter int unsigned CNT_W = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc_i,
  input  logic              sat_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [31:0]       wdata_lo_i,
  input  logic [CNT_W-33:0] wdata_hi_i,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              wrap_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Software write to either half takes priority and drops this cycle's increment
  always_comb begin
    cnt_d  = cnt_q;
    wrap_o = 1'b0;
    if (wr_lo_i || wr_hi_i) begin
      if (wr_lo_i) cnt_d[31:0]       = wdata_lo_i;
      if (wr_hi_i) cnt_d[CNT_W-1:32] = wdata_hi_i;
    end else if (inc_i) begin
      if (&cnt_q) begin
        if (!sat_i) begin
          cnt_d  = '0;
          wrap_o = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Counter state register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/zeroriscy_perf_counters.sv
// Perf-counter unit: CSR decode, EVSEL/INHIBIT/OVF registers, event mux and read mux.
module zeroriscy_perf_counters
  import zeroriscy_perf_counters_pkg::*;
#(
  parameter int unsigned N_CNT    = 8,
  parameter int unsigned CNT_W    = 40,
  parameter int unsigned N_EVENTS = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  zeroriscy_perf_counters_if.slave  bus,
  input  logic [N_EVENTS-1:0]       events_i,
  output logic                      ovf_irq_o
);

  logic [N_EVENTS-1:0] events_q, events_d;
  EvSel_t              evsel_q [N_CNT];
  EvSel_t              evsel_d [N_CNT];
  logic [N_CNT-1:0]    inhibit_q, inhibit_d;
  logic [N_CNT-1:0]    ovf_q, ovf_d;

  logic [CNT_W-1:0]    cnt [N_CNT];
  logic [N_CNT-1:0]    inc, wrap, wr_lo, wr_hi;
  logic [N_CNT-1:0]    sel_lo, sel_hi, sel_evsel, ovf_en;
  logic                sel_inhibit, sel_ovf, mapped, hit, we;
  logic [31:0]         rd_val, wval, ev_pad;

  // Address decode, read mux and the read-modify-write value (uses pre-edge state)
  always_comb begin
    sel_lo    = '0;
    sel_hi    = '0;
    sel_evsel = '0;
    rd_val    = '0;
    for (int i = 0; i < int'(N_CNT); i++) begin
      sel_lo[i]    = (bus.csr_addr_i == CSR_PERF_CNT_LO_BASE + 12'(i));
      sel_hi[i]    = (bus.csr_addr_i == CSR_PERF_CNT_HI_BASE + 12'(i));
      sel_evsel[i] = (bus.csr_addr_i == CSR_PERF_EVSEL_BASE + 12'(i));
      if (sel_lo[i])    rd_val = cnt[i][31:0];
      if (sel_hi[i])    rd_val = 32'(cnt[i][CNT_W-1:32]);
      if (sel_evsel[i]) rd_val = evsel_to_word(evsel_q[i]);
    end
    sel_inhibit = (bus.csr_addr_i == CSR_PERF_INHIBIT);
    sel_ovf     = (bus.csr_addr_i == CSR_PERF_OVF);
    if (sel_inhibit) rd_val = 32'(inhibit_q);
    if (sel_ovf)     rd_val = 32'(ovf_q);
    mapped = (|sel_lo) | (|sel_hi) | (|sel_evsel) | sel_inhibit | sel_ovf;
    hit    = bus.csr_access_i & mapped;
    we     = hit & (bus.csr_op_i != CSR_OP_NONE);
    wval   = rd_val;
    unique case (bus.csr_op_i)
      CSR_OP_NONE:  wval = rd_val;
      CSR_OP_WRITE: wval = bus.csr_wdata_i;
      CSR_OP_SET:   wval = rd_val | bus.csr_wdata_i;
      CSR_OP_CLEAR: wval = rd_val & ~bus.csr_wdata_i;
    endcase
  end

  assign bus.csr_hit_o   = hit;
  assign bus.csr_rdata_o = hit ? rd_val : '0;

  // Per-counter increment and write strobes; out-of-range idx reads a zero pad bit
  always_comb begin
    ev_pad = 32'(events_q);
    inc    = '0;
    wr_lo  = '0;
    wr_hi  = '0;
    ovf_en = '0;
    for (int i = 0; i < int'(N_CNT); i++) begin
      inc[i]    = ev_pad[evsel_q[i].idx] & ~inhibit_q[i];
      wr_lo[i]  = we & sel_lo[i];
      wr_hi[i]  = we & sel_hi[i];
      ovf_en[i] = evsel_q[i].ovf_en;
    end
  end

  for (genvar g = 0; g < int'(N_CNT); g++) begin : g_cnt
    zeroriscy_perf_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rst        (rst),
      .inc_i      (inc[g]),
      .sat_i      (evsel_q[g].sat),
      .wr_lo_i    (wr_lo[g]),
      .wr_hi_i    (wr_hi[g]),
      .wdata_lo_i (wval),
      .wdata_hi_i (wval[CNT_W-33:0]),
      .cnt_o      (cnt[g]),
      .wrap_o     (wrap[g])
    );
  end

  // Config/status next state; a hardware wrap overrides a same-cycle software clear
  always_comb begin
    events_d = events_i;
    for (int i = 0; i < int'(N_CNT); i++) begin
      evsel_d[i] = (we && sel_evsel[i]) ? evsel_from_word(wval) : evsel_q[i];
    end
    inhibit_d = (we && sel_inhibit) ? wval[N_CNT-1:0] : inhibit_q;
    ovf_d     = ((we && sel_ovf) ? wval[N_CNT-1:0] : ovf_q) | wrap;
  end

  // Config/status registers
  always_ff @(posedge clk) begin
    if (rst) begin
      events_q  <= '0;
      inhibit_q <= '1;
      ovf_q     <= '0;
      for (int i = 0; i < int'(N_CNT); i++) evsel_q[i] <= '0;
    end else begin
      events_q  <= events_d;
      inhibit_q <= inhibit_d;
      ovf_q     <= ovf_d;
      for (int i = 0; i < int'(N_CNT); i++) evsel_q[i] <= evsel_d[i];
    end
  end

  assign ovf_irq_o = |(ovf_q & ovf_en);

endmodule

// File: tb/tb_zeroriscy_perf_counters.sv
// Directed self-checking bench for the perf-counter unit.
module tb_zeroriscy_perf_counters;
  import zeroriscy_perf_counters_pkg::*;

  localparam int unsigned NCnt = 8;
  localparam int unsigned CntW = 40;
  localparam int unsigned NEv  = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [NEv-1:0]  events_i;
  logic            ovf_irq_o;
  int              total = 0;
  int              bad   = 0;

  zeroriscy_perf_counters_if bus ();

  zeroriscy_perf_counters #(
    .N_CNT    (NCnt),
    .CNT_W    (CntW),
    .N_EVENTS (NEv)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .events_i  (events_i),
    .ovf_irq_o (ovf_irq_o)
  );

  always #5 clk = ~clk;

  task automatic bus_idle();
    bus.csr_access_i = 1'b0;
    bus.csr_addr_i   = '0;
    bus.csr_wdata_i  = '0;
    bus.csr_op_i     = CSR_OP_NONE;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    @(negedge clk);
    bus.csr_access_i = 1'b1;
    bus.csr_addr_i   = a;
    bus.csr_op_i     = op;
    bus.csr_wdata_i  = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic csr_rd(input logic [11:0] a, output logic [31:0] d, output logic h);
    @(negedge clk);
    bus.csr_access_i = 1'b1;
    bus.csr_addr_i   = a;
    bus.csr_op_i     = CSR_OP_NONE;
    #1;
    d = bus.csr_rdata_o;
    h = bus.csr_hit_o;
    bus_idle();
  endtask

  task automatic pulse(input int idx);
    @(negedge clk);
    events_i      = '0;
    events_i[idx] = 1'b1;
    @(negedge clk);
    events_i      = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    rst = 1'b1;
    events_i = '0;
    bus_idle();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < int'(NCnt); i++) begin
      csr_rd(CSR_PERF_CNT_LO_BASE + 12'(i), d, h);
      total++;
      if (d !== 32'h0 || h !== 1'b1) begin
        bad++; $display("FAIL reset_lo%0d got=%h hit=%b exp=0 hit=1", i, d, h);
      end
      csr_rd(CSR_PERF_CNT_HI_BASE + 12'(i), d, h);
      total++;
      if (d !== 32'h0 || h !== 1'b1) begin
        bad++; $display("FAIL reset_hi%0d got=%h hit=%b exp=0 hit=1", i, d, h);
      end
      csr_rd(CSR_PERF_EVSEL_BASE + 12'(i), d, h);
      total++;
      if (d !== 32'h0 || h !== 1'b1) begin
        bad++; $display("FAIL reset_evsel%0d got=%h hit=%b exp=0 hit=1", i, d, h);
      end
    end
    csr_rd(CSR_PERF_INHIBIT, d, h);
    total++;
    if (d !== 32'hFF) begin bad++; $display("FAIL reset_inhibit got=%h exp=000000ff", d); end
    csr_rd(CSR_PERF_OVF, d, h);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL reset_ovf got=%h exp=0", d); end
    total++;
    if (ovf_irq_o !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b exp=0", ovf_irq_o); end
  endtask

  task automatic test_count();
    logic [31:0] d;
    logic        h;
    csr_wr(CSR_PERF_EVSEL_BASE, CSR_OP_WRITE, 32'd2);
    csr_wr(CSR_PERF_INHIBIT, CSR_OP_CLEAR, 32'h1);
    for (int k = 0; k < 5; k++) pulse(2);
    // One cycle after the last strobe: only four increments have landed
    bus.csr_access_i = 1'b1;
    bus.csr_addr_i   = CSR_PERF_CNT_LO_BASE;
    #1;
    total++;
    if (bus.csr_rdata_o !== 32'd4) begin
      bad++; $display("FAIL count_t1 got=%h exp=00000004", bus.csr_rdata_o);
    end
    @(negedge clk);
    #1;
    total++;
    if (bus.csr_rdata_o !== 32'd5) begin
      bad++; $display("FAIL count_t2 got=%h exp=00000005", bus.csr_rdata_o);
    end
    bus_idle();
    for (int i = 1; i < int'(NCnt); i++) begin
      csr_rd(CSR_PERF_CNT_LO_BASE + 12'(i), d, h);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL count_other%0d got=%h exp=0", i, d); end
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    logic        h;
    csr_wr(CSR_PERF_EVSEL_BASE + 12'd1, CSR_OP_WRITE, 32'h8000_0003);
    csr_wr(CSR_PERF_INHIBIT, CSR_OP_CLEAR, 32'h2);
    csr_wr(CSR_PERF_CNT_HI_BASE + 12'd1, CSR_OP_WRITE, 32'hFF);
    csr_wr(CSR_PERF_CNT_LO_BASE + 12'd1, CSR_OP_WRITE, 32'hFFFF_FFFF);
    pulse(3);
    #1;
    total++;
    if (ovf_irq_o !== 1'b0) begin bad++; $display("FAIL wrap_irq_early got=%b exp=0", ovf_irq_o); end
    csr_rd(CSR_PERF_CNT_LO_BASE + 12'd1, d, h);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wrap_lo got=%h exp=0", d); end
    csr_rd(CSR_PERF_CNT_HI_BASE + 12'd1, d, h);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wrap_hi got=%h exp=0", d); end
    csr_rd(CSR_PERF_OVF, d, h);
    total++;
    if (d !== 32'h2) begin bad++; $display("FAIL wrap_ovf got=%h exp=00000002", d); end
    total++;
    if (ovf_irq_o !== 1'b1) begin bad++; $display("FAIL wrap_irq got=%b exp=1", ovf_irq_o); end
    csr_wr(CSR_PERF_OVF, CSR_OP_CLEAR, 32'h2);
    #1;
    total++;
    if (ovf_irq_o !== 1'b0) begin bad++; $display("FAIL wrap_irq_clr got=%b exp=0", ovf_irq_o); end
    csr_rd(CSR_PERF_OVF, d, h);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL wrap_ovf_clr got=%h exp=0", d); end
  endtask

  task automatic test_saturate();
    logic [31:0] d;
    logic        h;
    csr_wr(CSR_PERF_EVSEL_BASE + 12'd1, CSR_OP_SET, 32'h4000_0000);
    csr_wr(CSR_PERF_CNT_HI_BASE + 12'd1, CSR_OP_WRITE, 32'hFF);
    csr_wr(CSR_PERF_CNT_LO_BASE + 12'd1, CSR_OP_WRITE, 32'hFFFF_FFFF);
    for (int k = 0; k < 3; k++) pulse(3);
    csr_rd(CSR_PERF_CNT_LO_BASE + 12'd1, d, h);
    total++;
    if (d !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_lo got=%h exp=ffffffff", d); end
    csr_rd(CSR_PERF_CNT_HI_BASE + 12'd1, d, h);
    total++;
    if (d !== 32'hFF) begin bad++; $display("FAIL sat_hi got=%h exp=000000ff", d); end
    csr_rd(CSR_PERF_OVF, d, h);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL sat_ovf got=%h exp=0", d); end
    total++;
    if (ovf_irq_o !== 1'b0) begin bad++; $display("FAIL sat_irq got=%b exp=0", ovf_irq_o); end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic        h;
    csr_wr(CSR_PERF_EVSEL_BASE + 12'd2, CSR_OP_WRITE, 32'd4);
    csr_wr(CSR_PERF_INHIBIT, CSR_OP_CLEAR, 32'h4);
    // Write lands on the same edge as the increment decision for the strobe
    @(negedge clk);
    events_i[4] = 1'b1;
    @(negedge clk);
    events_i = '0;
    bus.csr_access_i = 1'b1;
    bus.csr_addr_i   = CSR_PERF_CNT_LO_BASE + 12'd2;
    bus.csr_op_i     = CSR_OP_WRITE;
    bus.csr_wdata_i  = 32'h10;
    @(negedge clk);
    bus_idle();
    csr_rd(CSR_PERF_CNT_LO_BASE + 12'd2, d, h);
    total++;
    if (d !== 32'h10) begin bad++; $display("FAIL coll_write got=%h exp=00000010", d); end
    // Wrap on the same edge as a software clear of the same OVF bit
    csr_wr(CSR_PERF_CNT_HI_BASE + 12'd2, CSR_OP_WRITE, 32'hFF);
    csr_wr(CSR_PERF_CNT_LO_BASE + 12'd2, CSR_OP_WRITE, 32'hFFFF_FFFF);
    @(negedge clk);
    events_i[4] = 1'b1;
    @(negedge clk);
    events_i = '0;
    bus.csr_access_i = 1'b1;
    bus.csr_addr_i   = CSR_PERF_OVF;
    bus.csr_op_i     = CSR_OP_CLEAR;
    bus.csr_wdata_i  = 32'h4;
    @(negedge clk);
    bus_idle();
    csr_rd(CSR_PERF_OVF, d, h);
    total++;
    if (d !== 32'h4) begin bad++; $display("FAIL coll_ovf got=%h exp=00000004", d); end
    csr_rd(CSR_PERF_CNT_LO_BASE + 12'd2, d, h);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL coll_wrap_lo got=%h exp=0", d); end
    total++;
    if (ovf_irq_o !== 1'b0) begin bad++; $display("FAIL coll_irq_masked got=%b exp=0", ovf_irq_o); end
    csr_wr(CSR_PERF_EVSEL_BASE + 12'd2, CSR_OP_SET, 32'h8000_0000);
    #1;
    total++;
    if (ovf_irq_o !== 1'b1) begin bad++; $display("FAIL coll_irq_en got=%b exp=1", ovf_irq_o); end
  endtask

  task automatic test_inhibit_unmapped();
    logic [31:0] d;
    logic        h;
    logic [11:0] unm [4];
    unm[0] = CSR_PERF_CNT_LO_BASE + 12'(NCnt);
    unm[1] = CSR_PERF_CNT_HI_BASE + 12'(NCnt);
    unm[2] = CSR_PERF_EVSEL_BASE + 12'(NCnt);
    unm[3] = 12'h7C1;
    csr_wr(CSR_PERF_INHIBIT, CSR_OP_SET, 32'h5);
    csr_rd(CSR_PERF_INHIBIT, d, h);
    total++;
    if (d !== 32'hFD) begin bad++; $display("FAIL inh_set got=%h exp=000000fd", d); end
    csr_wr(CSR_PERF_INHIBIT, CSR_OP_WRITE, 32'hFFFF_FFFF);
    csr_rd(CSR_PERF_INHIBIT, d, h);
    total++;
    if (d !== 32'hFF) begin bad++; $display("FAIL inh_write got=%h exp=000000ff", d); end
    csr_wr(CSR_PERF_INHIBIT, CSR_OP_CLEAR, 32'h5);
    csr_rd(CSR_PERF_INHIBIT, d, h);
    total++;
    if (d !== 32'hFA) begin bad++; $display("FAIL inh_clear got=%h exp=000000fa", d); end
    for (int i = 0; i < 4; i++) begin
      csr_rd(unm[i], d, h);
      total++;
      if (d !== 32'h0 || h !== 1'b0) begin
        bad++; $display("FAIL unmapped%0d got=%h hit=%b exp=0 hit=0", i, d, h);
      end
    end
    csr_wr(unm[0], CSR_OP_WRITE, 32'h1234);
    csr_rd(CSR_PERF_CNT_LO_BASE, d, h);
    total++;
    if (d !== 32'd5) begin bad++; $display("FAIL unmapped_wr got=%h exp=00000005", d); end
    csr_wr(CSR_PERF_EVSEL_BASE + 12'd3, CSR_OP_WRITE, 32'hFFFF_FFFF);
    csr_rd(CSR_PERF_EVSEL_BASE + 12'd3, d, h);
    total++;
    if (d !== 32'hC000_001F) begin bad++; $display("FAIL evsel_mask got=%h exp=c000001f", d); end
  endtask

  task automatic test_reset_mid_count();
    logic [31:0] d;
    logic        h;
    // Counter 0 is enabled on event 2; reset arrives while the strobe sits in events_q
    @(negedge clk);
    events_i[2] = 1'b1;
    @(negedge clk);
    events_i = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    csr_rd(CSR_PERF_CNT_LO_BASE, d, h);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rstmid_cnt got=%h exp=0", d); end
    csr_rd(CSR_PERF_INHIBIT, d, h);
    total++;
    if (d !== 32'hFF) begin bad++; $display("FAIL rstmid_inh got=%h exp=000000ff", d); end
    csr_rd(CSR_PERF_OVF, d, h);
    total++;
    if (d !== 32'h0) begin bad++; $display("FAIL rstmid_ovf got=%h exp=0", d); end
    total++;
    if (ovf_irq_o !== 1'b0) begin bad++; $display("FAIL rstmid_irq got=%b exp=0", ovf_irq_o); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_count();
    test_wrap();
    test_saturate();
    test_collision();
    test_inhibit_unmapped();
    test_reset_mid_count();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
